irq_ctrl: RTL

- Interrupt controller/sequencer for the program-counter block.
- Latches edge-triggered interrupt requests and arbitrates them by fixed priority.
- At an instruction boundary, saves the next PC, redirects fetch to a per-line vector, then restores the saved PC on end-of-interrupt.
- Sits beside the PC block. Its redirect output overrides the PC mux with the same priority as a taken branch. The mask register is written through a bus destination port.

---
 rtl/irq_ctrl_if.sv | 27 ++
 rtl/irq_ctrl.sv | 61 ++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: signal bundle between the PC block side (master) and irq_ctrl (slave)
//   irq/mask_wr/mask_data/boundary/pc_next/eoi : master -> controller
//   redirect/redirect_pc/ack/active/pending/mask : controller -> master
interface irq_ctrl_if #(
  parameter int NIRQ = 4
);
  logic [NIRQ-1:0] irq;
  logic            mask_wr;
  logic [7:0]      mask_data;
  logic            boundary;
  logic [15:0]     pc_next;
  logic            eoi;
  logic            redirect;
  logic [15:0]     redirect_pc;
  logic [NIRQ-1:0] ack;
  logic            active;
  logic [NIRQ-1:0] pending;
  logic [7:0]      mask;
  modport master (
    output irq, mask_wr, mask_data, boundary, pc_next, eoi,
    input  redirect, redirect_pc, ack, active, pending, mask
  );
  modport slave (
    input  irq, mask_wr, mask_data, boundary, pc_next, eoi,
    output redirect, redirect_pc, ack, active, pending, mask
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, fixed-priority interrupt sequencer that redirects the PC to a vector and back
//   clk, rst (sync, active-low) ; bus : irq_ctrl_if.slave (requests, mask port, PC handshake, status)
module irq_ctrl #(
  parameter int          NIRQ          = 4,
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input logic        clk,
  input logic        rst,
  irq_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_SERVICE, S_RETURN} state_t;
  state_t          state_q, state_d;
  logic [NIRQ-1:0] irq_q, pending_q, pending_d, eligible, win_oh;
  logic [7:0]      mask_q;
  logic [15:0]     saved_pc_q;
  logic [2:0]      sel_q, win;
  logic            accept;
  assign eligible = pending_q & mask_q[NIRQ-1:0] & {NIRQ{mask_q[7]}};
  // descending scan so the lowest eligible index is the last one written
  always_comb begin
    win = '0;
    for (int i = NIRQ - 1; i >= 0; i--) if (eligible[i]) win = 3'(i);
  end
  assign accept = rst && state_q == S_IDLE && bus.boundary && |eligible;
  assign win_oh = accept ? NIRQ'(1) << win : '0;
  // new edges are OR-ed after the clear so a same-cycle set wins
  assign pending_d = (pending_q & ~win_oh) | (bus.irq & ~irq_q);
  always_comb begin
    state_d = state_q;
    state_d = accept                                ? S_REDIRECT :
              state_q == S_REDIRECT                 ? S_SERVICE  :
              (state_q == S_SERVICE && bus.eoi)     ? S_RETURN   :
              state_q == S_RETURN                   ? S_IDLE     : state_q;
  end
  always_ff @(posedge clk) begin
    irq_q <= bus.irq;
    if (!rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      mask_q     <= '0;
      saved_pc_q <= '0;
      sel_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (bus.mask_wr) mask_q <= bus.mask_data;
      if (accept) begin
        sel_q      <= win;
        saved_pc_q <= bus.pc_next;
      end
    end
  end
  assign bus.redirect    = state_q == S_REDIRECT || state_q == S_RETURN;
  assign bus.redirect_pc = state_q == S_REDIRECT ? VECTOR_BASE + 16'(sel_q) * VECTOR_STRIDE :
                           state_q == S_RETURN   ? saved_pc_q : '0;
  assign bus.ack         = win_oh;
  assign bus.active      = state_q != S_IDLE;
  assign bus.pending     = pending_q;
  assign bus.mask        = mask_q;
endmodule
